// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse receiver.
package ps2_pkg;

    // Frame receiver states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic        PS2_START          = 1'b0;
    localparam logic        PS2_STOP           = 1'b1;
    localparam int unsigned PS2_BYTE0_SYNC_BIT = 3;

    localparam int unsigned PS2_FILTER_LEN  = 8;
    localparam logic [15:0] PS2_TIMEOUT_CYC = 16'd50000;

    localparam int unsigned PS2_DATA_W = 8;
    localparam int unsigned PS2_PKT_W  = 25;
    localparam int unsigned PS2_TMR_W  = 16;

    // Odd parity over data bits plus the parity bit
    function automatic logic ps2_odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a consecutive-sample glitch filter.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = PS2_FILTER_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int unsigned CNT_W = $clog2(FILTER_LEN) + 1;

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dout_q;
    logic             dout_d;

    // Synchronizer and filter registers; the bus idles high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            dout_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], din};
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    // Count consecutive samples that disagree with the output; any agreeing sample restarts the run
    always_comb begin
        cnt_d  = '0;
        dout_d = dout_q;
        if (sync_q[1] != dout_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                dout_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: frame decoder plus 3-byte packet assembler.
module ps2_mouse_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = PS2_FILTER_LEN,
    parameter logic [15:0] TIMEOUT_CYC = PS2_TIMEOUT_CYC
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ps2_clk_in,
    input  logic                 ps2_data_in,
    output logic [PS2_PKT_W-1:0] ps2_mouse,
    output logic                 pkt_stb,
    output logic                 frame_err,
    output logic                 sync_err
);

    logic clk_f;
    logic data_f;
    logic clk_f_prev_q;
    logic fall_q;
    logic stop_ok_c;

    ps2_state_e            state_q,  state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [PS2_DATA_W-1:0] shift_q,  shift_d;
    logic                  parity_q, parity_d;
    logic [1:0]            idx_q,    idx_d;
    logic [PS2_DATA_W-1:0] byte0_q,  byte0_d;
    logic [PS2_DATA_W-1:0] byte1_q,  byte1_d;
    logic [PS2_PKT_W-1:0]  mouse_q,  mouse_d;
    logic                  pkt_stb_q,   pkt_stb_d;
    logic                  frame_err_q, frame_err_d;
    logic                  sync_err_q,  sync_err_d;
    logic [PS2_TMR_W-1:0]  bit_tmr_q, bit_tmr_d;
    logic [PS2_TMR_W-1:0]  pkt_tmr_q, pkt_tmr_d;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk   (clk),
        .reset (reset),
        .din   (ps2_clk_in),
        .dout  (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk   (clk),
        .reset (reset),
        .din   (ps2_data_in),
        .dout  (data_f)
    );

    // Filtered clock fall detect, delayed one cycle so data is sampled after the edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_f_prev_q <= 1'b1;
            fall_q       <= 1'b0;
        end else begin
            clk_f_prev_q <= clk_f;
            fall_q       <= clk_f_prev_q & ~clk_f;
        end
    end

    assign stop_ok_c = (data_f == PS2_STOP) && ps2_odd_parity_ok(shift_q, parity_q);

    // Frame FSM, packet assembler and timers: state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            idx_q       <= '0;
            byte0_q     <= '0;
            byte1_q     <= '0;
            mouse_q     <= '0;
            pkt_stb_q   <= 1'b0;
            frame_err_q <= 1'b0;
            sync_err_q  <= 1'b0;
            bit_tmr_q   <= '0;
            pkt_tmr_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            idx_q       <= idx_d;
            byte0_q     <= byte0_d;
            byte1_q     <= byte1_d;
            mouse_q     <= mouse_d;
            pkt_stb_q   <= pkt_stb_d;
            frame_err_q <= frame_err_d;
            sync_err_q  <= sync_err_d;
            bit_tmr_q   <= bit_tmr_d;
            pkt_tmr_q   <= pkt_tmr_d;
        end
    end

    // Next-state: timeouts first, then bit handling on a sampled fall
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        idx_d       = idx_q;
        byte0_d     = byte0_q;
        byte1_d     = byte1_q;
        mouse_d     = mouse_q;
        pkt_stb_d   = 1'b0;
        frame_err_d = 1'b0;
        sync_err_d  = 1'b0;
        bit_tmr_d   = bit_tmr_q;
        pkt_tmr_d   = pkt_tmr_q;

        // Bit timer runs only inside a frame and restarts on every fall
        if (state_q == IDLE || fall_q) begin
            bit_tmr_d = '0;
        end else if (bit_tmr_q != TIMEOUT_CYC) begin
            bit_tmr_d = bit_tmr_q + PS2_TMR_W'(1);
        end

        // Packet timer runs only while a packet is partially assembled
        if (idx_q == 2'd0) begin
            pkt_tmr_d = '0;
        end else if (pkt_tmr_q != TIMEOUT_CYC) begin
            pkt_tmr_d = pkt_tmr_q + PS2_TMR_W'(1);
        end

        // Stale partial packet is silently dropped
        if (idx_q != 2'd0 && pkt_tmr_q == TIMEOUT_CYC) begin
            idx_d = 2'd0;
        end

        if (state_q != IDLE && bit_tmr_q == TIMEOUT_CYC) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            idx_d       = 2'd0;
        end else if (fall_q) begin
            case (state_q)
                IDLE: begin
                    if (data_f == PS2_START) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {data_f, shift_q[PS2_DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = data_f;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!stop_ok_c) begin
                        frame_err_d = 1'b1;
                        idx_d       = 2'd0;
                    end else begin
                        pkt_tmr_d = '0;
                        case (idx_q)
                            2'd0: begin
                                if (shift_q[3'(PS2_BYTE0_SYNC_BIT)]) begin
                                    byte0_d = shift_q;
                                    idx_d   = 2'd1;
                                end else begin
                                    sync_err_d = 1'b1;
                                end
                            end
                            2'd1: begin
                                byte1_d = shift_q;
                                idx_d   = 2'd2;
                            end
                            default: begin
                                mouse_d   = {~mouse_q[PS2_PKT_W-1], shift_q, byte1_q, byte0_q};
                                pkt_stb_d = 1'b1;
                                idx_d     = 2'd0;
                            end
                        endcase
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign ps2_mouse = mouse_q;
    assign pkt_stb   = pkt_stb_q;
    assign frame_err = frame_err_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Self-checking bench for ps2_mouse_rx: vector table, directed corner cases, random packets.
`timescale 1ns/1ps
module tb_ps2_mouse_rx;

    localparam int unsigned FLEN = 8;
    localparam logic [15:0] TMO  = 16'd2000;
    localparam int          HALF = 40;   // 1 MHz clk -> 12.5 kHz PS/2 clock
    localparam int          GAP  = 60;

    logic        clk = 1'b0;
    logic        reset;
    logic        ps2_clk_in;
    logic        ps2_data_in;
    logic [24:0] ps2_mouse;
    logic        pkt_stb;
    logic        frame_err;
    logic        sync_err;

    int total = 0;
    int bad   = 0;

    int n_pkt  = 0;
    int n_ferr = 0;
    int n_serr = 0;

    // Byte-level reference model
    int          m_pkt   = 0;
    int          m_ferr  = 0;
    int          m_serr  = 0;
    int          m_idx   = 0;
    logic [7:0]  m_b0    = 8'h0;
    logic [7:0]  m_b1    = 8'h0;
    logic [24:0] m_mouse = 25'h0;

    typedef struct {
        logic [7:0]  data;
        int          err;       // 0 good, 1 bad parity, 2 bad stop bit
        int          exp_ferr;
        int          exp_serr;
        int          exp_pkt;
        logic [24:0] exp_mouse;
    } vec_t;

    vec_t vecs [21];

    ps2_mouse_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_mouse   (ps2_mouse),
        .pkt_stb     (pkt_stb),
        .frame_err   (frame_err),
        .sync_err    (sync_err)
    );

    always #500 clk = ~clk;

    // Pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (pkt_stb)   n_pkt  <= n_pkt + 1;
        if (frame_err) n_ferr <= n_ferr + 1;
        if (sync_err)  n_serr <= n_serr + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_byte(input logic [7:0] d, input bit good);
        if (!good) begin
            m_ferr++;
            m_idx = 0;
        end else if (m_idx == 0) begin
            if (d[3]) begin
                m_b0  = d;
                m_idx = 1;
            end else begin
                m_serr++;
            end
        end else if (m_idx == 1) begin
            m_b1  = d;
            m_idx = 2;
        end else begin
            m_mouse = {~m_mouse[24], d, m_b1, m_b0};
            m_pkt++;
            m_idx = 0;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int err);
        logic [10:0] bits;
        logic        par;
        par  = ~(^d);
        if (err == 1) par = ~par;
        bits = {1'((err == 2) ? 0 : 1), par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data_in = bits[i];
            wait_cyc(HALF);
            ps2_clk_in = 1'b0;
            wait_cyc(HALF);
            ps2_clk_in = 1'b1;
        end
        ps2_data_in = 1'b1;
        wait_cyc(HALF + GAP);
    endtask

    task automatic send_byte(input logic [7:0] d, input int err);
        send_frame(d, err);
        model_byte(d, err == 0);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_pkt"},   32'(n_pkt),  32'(m_pkt));
        check({tag, "_ferr"},  32'(n_ferr), 32'(m_ferr));
        check({tag, "_serr"},  32'(n_serr), 32'(m_serr));
        check({tag, "_mouse"}, 32'(ps2_mouse), 32'(m_mouse));
    endtask

    initial begin
        int p0;
        int f0;
        int s0;

        vecs[0]  = '{8'h09, 0, 0, 0, 0, 25'h0000000};
        vecs[1]  = '{8'h05, 0, 0, 0, 0, 25'h0000000};
        vecs[2]  = '{8'hFB, 0, 0, 0, 1, 25'h1FB0509};
        vecs[3]  = '{8'h00, 0, 0, 1, 1, 25'h1FB0509};
        vecs[4]  = '{8'h08, 0, 0, 1, 1, 25'h1FB0509};
        vecs[5]  = '{8'h01, 0, 0, 1, 1, 25'h1FB0509};
        vecs[6]  = '{8'h02, 0, 0, 1, 2, 25'h0020108};
        vecs[7]  = '{8'h18, 1, 1, 1, 2, 25'h0020108};
        vecs[8]  = '{8'h18, 0, 1, 1, 2, 25'h0020108};
        vecs[9]  = '{8'h34, 0, 1, 1, 2, 25'h0020108};
        vecs[10] = '{8'h56, 0, 1, 1, 3, 25'h1563418};
        vecs[11] = '{8'h28, 2, 2, 1, 3, 25'h1563418};
        vecs[12] = '{8'h0F, 0, 2, 1, 3, 25'h1563418};
        vecs[13] = '{8'h80, 0, 2, 1, 3, 25'h1563418};
        vecs[14] = '{8'h7F, 0, 2, 1, 4, 25'h07F800F};
        vecs[15] = '{8'h08, 0, 2, 1, 4, 25'h07F800F};
        vecs[16] = '{8'h44, 1, 3, 1, 4, 25'h07F800F};
        vecs[17] = '{8'h55, 0, 3, 2, 4, 25'h07F800F};
        vecs[18] = '{8'h09, 0, 3, 2, 4, 25'h07F800F};
        vecs[19] = '{8'hAA, 0, 3, 2, 4, 25'h07F800F};
        vecs[20] = '{8'hBB, 0, 3, 2, 5, 25'h1BBAA09};

        reset       = 1'b1;
        ps2_clk_in  = 1'b1;
        ps2_data_in = 1'b1;
        wait_cyc(5);
        check("rst_mouse",     32'(ps2_mouse), 32'h0);
        check("rst_pkt_stb",   32'(pkt_stb),   32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_sync_err",  32'(sync_err),  32'h0);
        reset = 1'b0;
        wait_cyc(20);

        // Vector table: valid packets, sync reject, parity and stop-bit errors
        for (int i = 0; i < 21; i++) begin
            send_byte(vecs[i].data, vecs[i].err);
            check($sformatf("vec%0d_ferr", i),  32'(n_ferr),    32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_serr", i),  32'(n_serr),    32'(vecs[i].exp_serr));
            check($sformatf("vec%0d_pkt", i),   32'(n_pkt),     32'(vecs[i].exp_pkt));
            check($sformatf("vec%0d_mouse", i), 32'(ps2_mouse), 32'(vecs[i].exp_mouse));
        end

        // Bit timeout: start bit plus 4 data bits, then the clock stops
        p0 = n_pkt;
        f0 = n_ferr;
        for (int i = 0; i < 5; i++) begin
            ps2_data_in = (i == 0) ? 1'b0 : 1'(i % 2);
            wait_cyc(HALF);
            ps2_clk_in = 1'b0;
            wait_cyc(HALF);
            ps2_clk_in = 1'b1;
        end
        ps2_data_in = 1'b1;
        wait_cyc(int'(TMO) + 200);
        m_ferr++;
        m_idx = 0;
        check("tmo_ferr", 32'(n_ferr), 32'(f0 + 1));
        send_byte(8'h0A, 0);
        send_byte(8'h10, 0);
        send_byte(8'h20, 0);
        check("tmo_next_pkt",   32'(n_pkt),          32'(p0 + 1));
        check("tmo_next_mouse", 32'(ps2_mouse[23:0]), 32'h20100A);
        check_model("tmo");

        // Short low glitch on the PS/2 clock with data low must not start a frame
        p0 = n_pkt;
        f0 = n_ferr;
        send_byte(8'h09, 0);
        ps2_data_in = 1'b0;
        wait_cyc(10);
        ps2_clk_in = 1'b0;
        wait_cyc(3);
        ps2_clk_in = 1'b1;
        wait_cyc(30);
        ps2_data_in = 1'b1;
        wait_cyc(30);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        check("glitch_ferr",  32'(n_ferr),           32'(f0));
        check("glitch_pkt",   32'(n_pkt),            32'(p0 + 1));
        check("glitch_mouse", 32'(ps2_mouse[23:0]), 32'h443309);
        check_model("glitch");

        // Packet timeout: lone byte0 goes stale, next three bytes form a fresh packet
        p0 = n_pkt;
        s0 = n_serr;
        send_byte(8'h08, 0);
        wait_cyc(int'(TMO) + 300);
        m_idx = 0;
        send_byte(8'h0C, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        check("ptmo_serr",  32'(n_serr),           32'(s0));
        check("ptmo_pkt",   32'(n_pkt),            32'(p0 + 1));
        check("ptmo_mouse", 32'(ps2_mouse[23:0]), 32'h22110C);
        check_model("ptmo");

        // Reset after byte1: partial packet is discarded, next packet starts bit24 from 0
        send_byte(8'h0B, 0);
        send_byte(8'h12, 0);
        p0 = n_pkt;
        reset = 1'b1;
        wait_cyc(5);
        check("mid_rst_mouse",   32'(ps2_mouse), 32'h0);
        check("mid_rst_pkt_stb", 32'(pkt_stb),   32'h0);
        reset = 1'b0;
        m_idx   = 0;
        m_mouse = 25'h0;
        wait_cyc(20);
        send_byte(8'h09, 0);
        send_byte(8'h05, 0);
        check("post_rst_no_pkt", 32'(n_pkt), 32'(p0));
        send_byte(8'hFB, 0);
        check("post_rst_pkt",   32'(n_pkt),     32'(p0 + 1));
        check("post_rst_mouse", 32'(ps2_mouse), 32'h1FB0509);
        check_model("rst");

        // Random packets with occasional corrupted frames
        for (int p = 0; p < 8; p++) begin
            for (int b = 0; b < 3; b++) begin
                logic [7:0] d;
                int         err;
                d = 8'($urandom);
                if (b == 0 && $urandom_range(0, 3) != 0) d[3] = 1'b1;
                err = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
                send_byte(d, err);
                check_model($sformatf("rnd%0d_%0d", p, b));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
